// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and state encodings for the pipeline stage registers.
package pipe_stage_reg_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic StallEnable  = 1'b1;
  localparam logic StallDisable = 1'b0;

  typedef enum logic [1:0] {
    PIPE_ST_FLOW   = 2'd0,
    PIPE_ST_BUBBLE = 2'd1,
    PIPE_ST_HOLD   = 2'd2,
    PIPE_ST_FLUSH  = 2'd3
  } pipe_st_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: holds at all-ones, cleared only by synchronous reset.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush handling, multi-cycle side
// state carried across stalls, and saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W     = 146,
  parameter int unsigned       CARRY_W    = 66,
  parameter int unsigned       STALL_W    = 6,
  parameter int unsigned       STAGE      = 3,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       PERF_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CARRY_W-1:0] carry_i,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CARRY_W-1:0] carry_o,
  output logic [1:0]         state_o,
  output logic [PERF_W-1:0]  stall_cnt,
  output logic [PERF_W-1:0]  bubble_cnt
);

  logic     stall_here;
  logic     down_stall;
  logic     stall_unused;
  logic     inc_stall;
  logic     inc_bubble;
  pipe_st_e state_q;

  assign stall_here   = stall[STAGE];
  assign stall_unused = ^stall;

  // The last stage has no downstream register, so it can only ever bubble.
  generate
    if (STAGE < STALL_W - 1) begin : g_down
      assign down_stall = stall[STAGE+1];
    end else begin : g_last
      assign down_stall = StallDisable;
    end
  endgenerate

  // Flush wins over stall, so a flush edge counts one bubble and no stall.
  always_comb begin
    inc_stall  = 1'b0;
    inc_bubble = 1'b0;
    if (flush) begin
      inc_bubble = 1'b1;
    end else if (stall_here == StallEnable) begin
      inc_stall  = 1'b1;
      inc_bubble = (down_stall == StallDisable);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      out_data  <= BUBBLE_VAL;
      out_valid <= 1'b0;
      carry_o   <= '0;
      state_q   <= PIPE_ST_FLOW;
    end else if (flush) begin
      out_data  <= BUBBLE_VAL;
      out_valid <= 1'b0;
      carry_o   <= '0;
      state_q   <= PIPE_ST_FLUSH;
    end else if ((stall_here == StallEnable) && (down_stall == StallDisable)) begin
      out_data  <= BUBBLE_VAL;
      out_valid <= 1'b0;
      carry_o   <= carry_i;
      state_q   <= PIPE_ST_BUBBLE;
    end else if (stall_here == StallDisable) begin
      out_data  <= in_data;
      out_valid <= in_valid;
      carry_o   <= '0;
      state_q   <= PIPE_ST_FLOW;
    end else begin
      carry_o   <= carry_i;
      state_q   <= PIPE_ST_HOLD;
    end
  end

  assign state_o = state_q;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_stall),
    .q   (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_bubble),
    .q   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: main, saturating and last-stage configurations.
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst;
  logic [5:0]   s0, s1, s2;
  logic         f0, f1, f2;
  logic         in_valid;
  logic [145:0] in_data;
  logic [65:0]  carry_i;

  logic         v0, v1, v2;
  logic [145:0] d0, d1, d2;
  logic [65:0]  c0, c1, c2;
  logic [1:0]   st0, st1, st2;
  logic [15:0]  sc0, bc0, sc2, bc2;
  logic [3:0]   sc1, bc1;

  int tests_run;
  int fails;

  logic [151:0] pat_wide;
  logic [145:0] pat_a, pat_d;
  logic [65:0]  car_a, car_b;

  pipe_stage_reg #(.DATA_W(146), .CARRY_W(66), .STALL_W(6), .STAGE(3), .PERF_W(16)) dut (
    .clk(clk), .rst(rst), .stall(s0), .flush(f0), .in_valid(in_valid), .in_data(in_data),
    .carry_i(carry_i), .out_valid(v0), .out_data(d0), .carry_o(c0), .state_o(st0),
    .stall_cnt(sc0), .bubble_cnt(bc0)
  );

  pipe_stage_reg #(.DATA_W(146), .CARRY_W(66), .STALL_W(6), .STAGE(3), .PERF_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(s1), .flush(f1), .in_valid(in_valid), .in_data(in_data),
    .carry_i(carry_i), .out_valid(v1), .out_data(d1), .carry_o(c1), .state_o(st1),
    .stall_cnt(sc1), .bubble_cnt(bc1)
  );

  pipe_stage_reg #(.DATA_W(146), .CARRY_W(66), .STALL_W(6), .STAGE(5), .PERF_W(16)) dut_last (
    .clk(clk), .rst(rst), .stall(s2), .flush(f2), .in_valid(in_valid), .in_data(in_data),
    .carry_i(carry_i), .out_valid(v2), .out_data(d2), .carry_o(c2), .state_o(st2),
    .stall_cnt(sc2), .bubble_cnt(bc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = '1; carry_i = '1;
    s0 = '0; s1 = '0; s2 = '0; f0 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    tick();
    tick();
    tests_run++; if (d0 !== 146'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", d0); end
    tests_run++; if (v0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", v0); end
    tests_run++; if (c0 !== 66'd0) begin fails++; $display("FAIL reset_carry: got %h expected 0", c0); end
    tests_run++; if (st0 !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", st0); end
    tests_run++; if (sc0 !== 16'd0 || bc0 !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", sc0, bc0); end
    tests_run++; if (sc1 !== 4'd0 || sc2 !== 16'd0 || bc2 !== 16'd0) begin fails++; $display("FAIL reset_cnt_other: got %0d/%0d/%0d expected 0/0/0", sc1, sc2, bc2); end
  endtask

  task automatic test_flow();
    rst = 1'b0; in_valid = 1'b1; in_data = pat_a; carry_i = car_a;
    tick();
    tests_run++; if (d0 !== pat_a) begin fails++; $display("FAIL flow_data: got %h expected %h", d0, pat_a); end
    tests_run++; if (v0 !== 1'b1) begin fails++; $display("FAIL flow_valid: got %b expected 1", v0); end
    tests_run++; if (c0 !== 66'd0) begin fails++; $display("FAIL flow_carry: got %h expected 0", c0); end
    tests_run++; if (st0 !== 2'd0) begin fails++; $display("FAIL flow_state: got %0d expected 0", st0); end
    in_valid = 1'b0; in_data = pat_d;
    tick();
    tests_run++; if (d0 !== pat_d || v0 !== 1'b0) begin fails++; $display("FAIL flow_invalid: got %h/%b expected %h/0", d0, v0, pat_d); end
    in_valid = 1'b1; in_data = pat_a;
    tick();
    tests_run++; if (sc0 !== 16'd0 || bc0 !== 16'd0) begin fails++; $display("FAIL flow_cnt: got %0d/%0d expected 0/0", sc0, bc0); end
  endtask

  task automatic test_bubble_hold();
    s0 = 6'b001111; carry_i = car_a;
    tick();
    tests_run++; if (d0 !== 146'd0 || v0 !== 1'b0) begin fails++; $display("FAIL bubble_data: got %h/%b expected 0/0", d0, v0); end
    tests_run++; if (c0 !== car_a) begin fails++; $display("FAIL bubble_carry: got %h expected %h", c0, car_a); end
    tests_run++; if (st0 !== 2'd1) begin fails++; $display("FAIL bubble_state: got %0d expected 1", st0); end
    tests_run++; if (bc0 !== 16'd1 || sc0 !== 16'd1) begin fails++; $display("FAIL bubble_cnt: got b%0d s%0d expected b1 s1", bc0, sc0); end
    s0 = 6'b011111; carry_i = car_b; in_data = ~pat_a;
    tick();
    tests_run++; if (d0 !== 146'd0 || v0 !== 1'b0) begin fails++; $display("FAIL hold1_data: got %h/%b expected 0/0", d0, v0); end
    tests_run++; if (st0 !== 2'd2) begin fails++; $display("FAIL hold1_state: got %0d expected 2", st0); end
    tests_run++; if (sc0 !== 16'd2 || bc0 !== 16'd1) begin fails++; $display("FAIL hold1_cnt: got s%0d b%0d expected s2 b1", sc0, bc0); end
    tests_run++; if (c0 !== car_b) begin fails++; $display("FAIL hold1_carry: got %h expected %h", c0, car_b); end
    s0 = 6'b000000; in_data = pat_d; in_valid = 1'b1; carry_i = car_a;
    tick();
    tests_run++; if (d0 !== pat_d || v0 !== 1'b1 || c0 !== 66'd0) begin fails++; $display("FAIL reflow: got %h/%b/%h expected %h/1/0", d0, v0, c0, pat_d); end
    s0 = 6'b011111; in_data = ~pat_d; in_valid = 1'b0; carry_i = car_b;
    tick();
    tests_run++; if (d0 !== pat_d || v0 !== 1'b1) begin fails++; $display("FAIL hold2_data: got %h/%b expected %h/1", d0, v0, pat_d); end
    tests_run++; if (c0 !== car_b || sc0 !== 16'd3) begin fails++; $display("FAIL hold2_carry_cnt: got %h/%0d expected %h/3", c0, sc0, car_b); end
  endtask

  task automatic test_flush();
    s0 = 6'b011111; f0 = 1'b1;
    tick();
    tests_run++; if (d0 !== 146'd0 || v0 !== 1'b0) begin fails++; $display("FAIL flush_data: got %h/%b expected 0/0", d0, v0); end
    tests_run++; if (c0 !== 66'd0) begin fails++; $display("FAIL flush_carry: got %h expected 0", c0); end
    tests_run++; if (st0 !== 2'd3) begin fails++; $display("FAIL flush_state: got %0d expected 3", st0); end
    tests_run++; if (sc0 !== 16'd3 || bc0 !== 16'd2) begin fails++; $display("FAIL flush_cnt: got s%0d b%0d expected s3 b2", sc0, bc0); end
    s0 = 6'b001111;
    tick();
    tests_run++; if (sc0 !== 16'd3 || bc0 !== 16'd3 || st0 !== 2'd3) begin fails++; $display("FAIL flush_bubble_once: got s%0d b%0d st%0d expected s3 b3 st3", sc0, bc0, st0); end
    s0 = 6'b000000; in_valid = 1'b1; in_data = pat_a;
    tick();
    tests_run++; if (bc0 !== 16'd4 || v0 !== 1'b0) begin fails++; $display("FAIL flush_b2b: got b%0d v%b expected b4 v0", bc0, v0); end
    f0 = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    s0 = 6'b000000; in_valid = 1'b1; in_data = pat_d;
    tick();
    s0 = 6'b011111; carry_i = car_a;
    tick();
    tests_run++; if (d0 !== pat_d || sc0 !== 16'd4 || c0 !== car_a) begin fails++; $display("FAIL pre_rst_hold: got %h/%0d/%h expected %h/4/%h", d0, sc0, c0, pat_d, car_a); end
    rst = 1'b1;
    tick();
    tests_run++; if (d0 !== 146'd0 || v0 !== 1'b0 || c0 !== 66'd0) begin fails++; $display("FAIL rst_stall_data: got %h/%b/%h expected 0/0/0", d0, v0, c0); end
    tests_run++; if (st0 !== 2'd0 || sc0 !== 16'd0 || bc0 !== 16'd0) begin fails++; $display("FAIL rst_stall_cnt: got st%0d s%0d b%0d expected 0/0/0", st0, sc0, bc0); end
    rst = 1'b0; s0 = 6'b000000;
  endtask

  task automatic test_saturation();
    logic [3:0] exp;
    s1 = 6'b011000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = (i > 15) ? 4'd15 : 4'(i);
      tests_run++; if (sc1 !== exp) begin fails++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, sc1, exp); end
    end
    tests_run++; if (bc1 !== 4'd0 || st1 !== 2'd2) begin fails++; $display("FAIL sat_hold: got b%0d st%0d expected b0 st2", bc1, st1); end
    s1 = 6'b000000;
  endtask

  task automatic test_last_stage();
    s2 = 6'b111111; carry_i = car_b;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++; if (st2 !== 2'd1 || bc2 !== 16'(i) || sc2 !== 16'(i)) begin fails++; $display("FAIL last_stage[%0d]: got st%0d b%0d s%0d expected st1 b%0d s%0d", i, st2, bc2, sc2, i, i); end
    end
    tests_run++; if (v2 !== 1'b0 || c2 !== car_b) begin fails++; $display("FAIL last_stage_out: got v%b c%h expected v0 c%h", v2, c2, car_b); end
    s2 = 6'b000000;
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    pat_wide = {19{8'h5A}};
    pat_a = pat_wide[145:0];
    pat_wide = {19{8'hC3}};
    pat_d = pat_wide[145:0];
    car_a = 66'h2_DEADBEEF_00000001;
    car_b = 66'h1_12345678_9ABCDEF0;
    test_reset();
    test_flow();
    test_bubble_hold();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_last_stage();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
